// File: rtl/ccx4_responder.sv
// Nibble-serial coprocessor responder: captures two XLEN operands 4 bits at a time,
// executes ADD/XOR/MIN (and shift-add MUL when CCX4_MULT_EN is defined), streams the result back.
module ccx4_responder #(
  parameter int XLEN = 32,
  parameter int NIB  = XLEN / 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ccx_req_i,
  input  logic [1:0] ccx_sel_i,
  input  logic [3:0] ccx_rs_a_i,
  input  logic [3:0] ccx_rs_b_i,
  output logic [3:0] ccx_res_o,
  output logic       ccx_resp_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);
  localparam logic [CW-1:0] NIBS     = CW'(NIB);
`ifdef CCX4_MULT_EN
  localparam logic [CW-1:0] LAST_BIT = CW'(XLEN - 1);
`endif

  typedef enum logic [1:0] {IDLE, CAPTURE, EXEC, RESPOND} state_t;

  state_t          state;
  logic [1:0]      sel;
  logic [XLEN-1:0] a, b, result, out_sr, alu;
  logic [CW-1:0]   cnt;

  assign busy_o = (state != IDLE);

  always_comb begin
    alu = '0;
    case (sel)
      2'b00:   alu = a + b;
      2'b01:   alu = a ^ b;
      2'b10:   alu = (a < b) ? a : b;
      default: alu = '0;
    endcase
  end

`ifdef CCX4_MULT_EN
  // Shift-add step: A drains LSB-first while B slides left, so a[0] always weights the current B.
  logic [XLEN-1:0] acc_next;
  assign acc_next = result + (a[0] ? b : '0);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      sel        <= '0;
      a          <= '0;
      b          <= '0;
      result     <= '0;
      out_sr     <= '0;
      cnt        <= '0;
      ccx_res_o  <= '0;
      ccx_resp_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ccx_resp_o <= 1'b0;
          ccx_res_o  <= '0;
          if (ccx_req_i) begin
            // Operands shift in from the top so nibble 0 lands at the bottom after NIB shifts.
            sel    <= ccx_sel_i;
            a      <= {ccx_rs_a_i, {(XLEN-4){1'b0}}};
            b      <= {ccx_rs_b_i, {(XLEN-4){1'b0}}};
            result <= '0;
            cnt    <= CW'(1);
            state  <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (ccx_req_i) begin
            a <= {ccx_rs_a_i, a[XLEN-1:4]};
            b <= {ccx_rs_b_i, b[XLEN-1:4]};
            if (cnt == LAST_NIB) begin
              cnt   <= '0;
              state <= EXEC;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            a     <= '0;
            b     <= '0;
            cnt   <= '0;
            err_o <= 1'b1;
            state <= IDLE;
          end
        end

        EXEC: begin
          if (ccx_req_i) err_o <= 1'b1;
          if (sel == 2'b11) begin
`ifdef CCX4_MULT_EN
            a <= a >> 1;
            b <= b << 1;
            if (cnt == LAST_BIT) begin
              result     <= acc_next;
              out_sr     <= acc_next >> 4;
              ccx_res_o  <= acc_next[3:0];
              ccx_resp_o <= 1'b1;
              cnt        <= CW'(1);
              state      <= RESPOND;
            end else begin
              result <= acc_next;
              cnt    <= cnt + CW'(1);
            end
`else
            result     <= '0;
            out_sr     <= '0;
            ccx_res_o  <= '0;
            ccx_resp_o <= 1'b1;
            err_o      <= 1'b1;
            cnt        <= CW'(1);
            state      <= RESPOND;
`endif
          end else begin
            result     <= alu;
            out_sr     <= alu >> 4;
            ccx_res_o  <= alu[3:0];
            ccx_resp_o <= 1'b1;
            cnt        <= CW'(1);
            state      <= RESPOND;
          end
        end

        RESPOND: begin
          if (ccx_req_i) err_o <= 1'b1;
          if (cnt == NIBS) begin
            ccx_resp_o <= 1'b0;
            ccx_res_o  <= '0;
            cnt        <= '0;
            state      <= IDLE;
          end else begin
            ccx_res_o <= out_sr[3:0];
            out_sr    <= out_sr >> 4;
            cnt       <= cnt + CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccx4_responder.sv
// Directed bench for ccx4_responder; define CCX4_MULT_EN here too when building the multiplier variant.
module tb_ccx4_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [1:0] sel;
  logic [3:0] rs_a, rs_b;
  logic [3:0] res_o;
  logic       resp, busy, err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ccx4_responder dut (
    .clk_i(clk), .rst_i(rst), .ccx_req_i(req), .ccx_sel_i(sel),
    .ccx_rs_a_i(rs_a), .ccx_rs_b_i(rs_b), .ccx_res_o(res_o),
    .ccx_resp_o(resp), .busy_o(busy), .err_o(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; req = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  // Drives all 8 nibbles; sel is inverted after the first cycle and must be ignored.
  task automatic send(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req  = 1'b1;
      sel  = (i == 0) ? s : ~s;
      rs_a = a[4*i +: 4];
      rs_b = b[4*i +: 4];
    end
  endtask

  task automatic collect(input bit poke, output logic [31:0] res, output int lat,
                         output int len, output int stray);
    res = '0; lat = 0; len = 0; stray = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      req = 1'b0;
      if (poke && len == 3) req = 1'b1;
      if (resp) begin
        if (len < 8) res[4*len +: 4] = res_o;
        if (lat == 0) lat = k;
        len++;
      end else begin
        if (res_o != 4'h0) stray++;
        if (len > 0) break;
      end
    end
    req = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] r; int lat, len, stray;
    send(s, a, b);
    collect(1'b0, r, lat, len, stray);
    chk({tag, "_res"}, 64'(r), 64'(exp));
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_len"}, 64'(len), 64'd8);
    chk({tag, "_res0_idle"}, 64'(stray), 64'd0);
  endtask

  initial begin
    logic [31:0] r; int lat, len, stray, seen;
    rst = 1'b0; req = 1'b0; sel = '0; rs_a = '0; rs_b = '0;

    do_reset();
    chk("rst_resp", 64'(resp), 64'd0);
    chk("rst_res",  64'(res_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err",  64'(err), 64'd0);

    run_op("add_f_1", 2'b00, 32'h0000_000F, 32'h0000_0001, 32'h0000_0010, 2);
    chk("add_err", 64'(err), 64'd0);
    chk("add_busy_after", 64'(busy), 64'd0);
    run_op("add_wrap", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 2);
    run_op("xor",      2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 2);
    run_op("min",      2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 2);
    run_op("min_rev",  2'b10, 32'h0000_0100, 32'h8000_0000, 32'h0000_0100, 2);
    chk("ops_err", 64'(err), 64'd0);

    // Abort after three nibbles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); req = 1'b1; sel = 2'b00; rs_a = 4'h1; rs_b = 4'h1;
    end
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_err",  64'(err), 64'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp) seen++;
    end
    chk("abort_no_resp", 64'(seen), 64'd0);
    run_op("add_2_3", 2'b00, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 2);

    // Request during RESPOND is ignored but flagged.
    do_reset();
    chk("rst2_err", 64'(err), 64'd0);
    send(2'b00, 32'h1234_5678, 32'h1111_1111);
    collect(1'b1, r, lat, len, stray);
    chk("poke_res", 64'(r), 64'h2345_6789);
    chk("poke_len", 64'(len), 64'd8);
    chk("poke_err", 64'(err), 64'd1);
    chk("poke_idle", 64'(busy), 64'd0);

    do_reset();
`ifdef CCX4_MULT_EN
    run_op("mul", 2'b11, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 33);
    chk("mul_err", 64'(err), 64'd0);
`else
    run_op("mul_off", 2'b11, 32'h0001_0003, 32'h0002_0005, 32'h0000_0000, 2);
    chk("mul_off_err", 64'(err), 64'd1);
`endif

    // Reset after two result nibbles.
    send(2'b01, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
    seen = 0;
    for (int k = 0; k < 20 && seen < 2; k++) begin
      @(negedge clk); req = 1'b0;
      if (resp) seen++;
    end
    chk("rstmid_nibs", 64'(seen), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_resp", 64'(resp), 64'd0);
    chk("rstmid_res",  64'(res_o), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_err",  64'(err), 64'd0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp) seen++;
    end
    chk("rstmid_no_more", 64'(seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
